// File: rtl/food_spawner.sv
// food_spawner
//   Places a food item on the snake playfield by drawing coordinates from a
//   free-running LFSR word. A draw is rejected when it falls outside the grid
//   or when the occupancy store reports that the snake body covers the cell.
//   Rejected draws are retried after a gap of DRAW_GAP cycles. The gap lets
//   the shift-by-1 LFSR produce fresh bits. After MAX_TRIES rejects the spawn
//   gives up.
//
// Ports
//   clk, rst     system clock; synchronous active-high reset
//   rnd          PRNG word, sampled only in the DRAW state
//   spawn_req    1-cycle request to place new food (ignored while busy)
//   occ_req      1-cycle occupancy lookup strobe for (occ_x, occ_y)
//   occ_x/occ_y  lookup coordinate, stable from DRAW until the result cycle
//   occ_hit      lookup result, valid exactly one cycle after occ_req
//   food_x/y     placed food coordinate
//   food_valid   food_x/food_y hold a placed, unoccupied cell
//   busy         high whenever a spawn is in progress
//   spawn_done   1-cycle pulse on successful placement
//   spawn_fail   1-cycle pulse when MAX_TRIES rejects are used up
module food_spawner #(
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int X_BITS    = 6,
  parameter int Y_BITS    = 5,
  parameter int DRAW_GAP  = 16,
  parameter int MAX_TRIES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       rnd,
  input  logic              spawn_req,
  output logic              occ_req,
  output logic [X_BITS-1:0] occ_x,
  output logic [Y_BITS-1:0] occ_y,
  input  logic              occ_hit,
  output logic [X_BITS-1:0] food_x,
  output logic [Y_BITS-1:0] food_y,
  output logic              food_valid,
  output logic              busy,
  output logic              spawn_done,
  output logic              spawn_fail
);

  localparam int GAP_W = $clog2(DRAW_GAP + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(DRAW_GAP - 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
  // One extra bit keeps the bound representable when GRID_* == 2***_BITS.
  localparam logic [X_BITS:0]  X_LIMIT   = (X_BITS + 1)'(GRID_W);
  localparam logic [Y_BITS:0]  Y_LIMIT   = (Y_BITS + 1)'(GRID_H);

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    DRAW,
    CHECK,
    RESULT
  } state_t;

  state_t state, state_nxt;

  logic [GAP_W-1:0]  gap_cnt;
  logic [TRY_W-1:0]  tries;
  logic [X_BITS-1:0] cx;
  logic [Y_BITS-1:0] cy;
  logic              off_grid;
  logic              last_try;

  assign cx = rnd[X_BITS-1:0];
  assign cy = rnd[X_BITS+Y_BITS-1:X_BITS];

  generate
    if (X_BITS + Y_BITS < 16) begin : g_spare_rnd
      logic unused_rnd;
      assign unused_rnd = ^rnd[15:X_BITS+Y_BITS];
    end
  endgenerate

  assign off_grid = ({1'b0, cx} >= X_LIMIT) || ({1'b0, cy} >= Y_LIMIT);
  // The reject being handled this cycle is the final allowed one.
  assign last_try = ((tries + 1'b1) == TRY_LIMIT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (spawn_req) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (off_grid) begin
          state_nxt = last_try ? IDLE : GAP;
        end else begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        state_nxt = RESULT;
      end
      RESULT: begin
        if (occ_hit) begin
          state_nxt = last_try ? IDLE : GAP;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Moore outputs
  always_comb begin
    occ_req = 1'b0;
    busy    = 1'b1;
    unique case (state)
      IDLE:    busy    = 1'b0;
      CHECK:   occ_req = 1'b1;
      default: ;
    endcase
  end

  // Datapath: gap timer, try counter, lookup coordinate, food result
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt    <= '0;
      tries      <= '0;
      occ_x      <= '0;
      occ_y      <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
    end else begin
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
      unique case (state)
        IDLE: begin
          if (spawn_req) begin
            food_valid <= 1'b0;
            tries      <= '0;
            gap_cnt    <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DRAW: begin
          if (off_grid) begin
            tries <= tries + 1'b1;
            if (last_try) begin
              spawn_fail <= 1'b1;
            end else begin
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            occ_x <= cx;
            occ_y <= cy;
          end
        end
        RESULT: begin
          if (occ_hit) begin
            tries <= tries + 1'b1;
            if (last_try) begin
              spawn_fail <= 1'b1;
            end else begin
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            food_x     <= occ_x;
            food_y     <= occ_y;
            food_valid <= 1'b1;
            spawn_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner
//   Directed and randomized checks of food_spawner. A reference model predicts
//   the outcome of each spawn. It uses the rnd words for each cycle and a random
//   occupancy map. The bench also answers occupancy lookups from the same map.
module tb_food_spawner;

  localparam int DG = 16;
  localparam int MT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rnd;
  logic        spawn_req;
  logic        occ_req;
  logic [5:0]  occ_x;
  logic [4:0]  occ_y;
  logic        occ_hit;
  logic [5:0]  food_x;
  logic [4:0]  food_y;
  logic        food_valid;
  logic        busy;
  logic        spawn_done;
  logic        spawn_fail;

  int n_cmp  = 0;
  int n_fail = 0;

  int unsigned rseq [0:199];
  bit          occ  [0:39][0:29];

  food_spawner #(
    .GRID_W   (40),
    .GRID_H   (30),
    .X_BITS   (6),
    .Y_BITS   (5),
    .DRAW_GAP (DG),
    .MAX_TRIES(MT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rnd       (rnd),
    .spawn_req (spawn_req),
    .occ_req   (occ_req),
    .occ_x     (occ_x),
    .occ_y     (occ_y),
    .occ_hit   (occ_hit),
    .food_x    (food_x),
    .food_y    (food_y),
    .food_valid(food_valid),
    .busy      (busy),
    .spawn_done(spawn_done),
    .spawn_fail(spawn_fail)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rseq(input int unsigned v);
    for (int i = 0; i < 200; i++) rseq[i] = v;
  endtask

  task automatic clear_occ();
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++)
        occ[x][y] = 1'b0;
  endtask

  // Runs one spawn starting in the current cycle (cycle 0 = spawn_req driven).
  // force_hits: the first N lookups report occupied regardless of the map.
  task automatic run_spawn(input string name, input int force_hits, input bit extra_req);
    int endc, t, tries, nl, lk;
    bit ok;
    int rq_c [0:7];
    int rq_x [0:7];
    int rq_y [0:7];
    int fx, fy, cx, cy;
    bit hit, pend_v, pend_h, exp_req;
    int ex, ey;

    // Reference model: walk the draws with the spec's latency rules.
    t = DG + 1; tries = 0; nl = 0; endc = -1; ok = 0; fx = 0; fy = 0;
    while (endc < 0) begin
      cx = int'(rseq[t] % 64);
      cy = int'((rseq[t] / 64) % 32);
      if (cx >= 40 || cy >= 30) begin
        tries++;
        if (tries == MT) endc = t + 1;
        else t += DG + 1;
      end else begin
        rq_c[nl] = t + 1; rq_x[nl] = cx; rq_y[nl] = cy;
        hit = (nl < force_hits) ? 1'b1 : occ[cx][cy];
        nl++;
        if (!hit) begin
          endc = t + 3; ok = 1; fx = cx; fy = cy;
        end else begin
          tries++;
          if (tries == MT) endc = t + 3;
          else t += DG + 3;
        end
      end
    end

    spawn_req = 1'b1;
    rnd       = 16'(rseq[0]);
    occ_hit   = 1'($urandom);
    pend_v = 0; pend_h = 0; lk = 0;
    for (int c = 1; c <= endc + 1; c++) begin
      tick();
      exp_req = 0; ex = 0; ey = 0;
      for (int j = 0; j < nl; j++) begin
        if (rq_c[j] == c) begin
          exp_req = 1; ex = rq_x[j]; ey = rq_y[j];
        end
      end
      chk({name, ".occ_req"}, 32'(occ_req), 32'(exp_req));
      if (exp_req) begin
        chk({name, ".occ_x"}, 32'(occ_x), 32'(ex));
        chk({name, ".occ_y"}, 32'(occ_y), 32'(ey));
      end
      chk({name, ".busy"},       32'(busy),       32'(c < endc));
      chk({name, ".spawn_done"}, 32'(spawn_done), 32'(c == endc && ok));
      chk({name, ".spawn_fail"}, 32'(spawn_fail), 32'(c == endc && !ok));
      chk({name, ".food_valid"}, 32'(food_valid), 32'(c >= endc && ok));
      if (c >= endc && ok) begin
        chk({name, ".food_x"}, 32'(food_x), 32'(fx));
        chk({name, ".food_y"}, 32'(food_y), 32'(fy));
      end
      // Drive inputs for this cycle; the occupancy store answers one cycle late.
      spawn_req = (extra_req && c < endc) ? 1'($urandom) : 1'b0;
      rnd       = 16'(rseq[c]);
      occ_hit   = pend_v ? pend_h : 1'($urandom);
      if (occ_req) begin
        pend_v = 1;
        if (lk < force_hits) pend_h = 1;
        else if (occ_x < 40 && occ_y < 30) pend_h = occ[occ_x][occ_y];
        else pend_h = 1;
        lk++;
      end else begin
        pend_v = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; rnd = '0; spawn_req = 1'b0; occ_hit = 1'b0;
    clear_occ();
    tick(); tick();
    chk("rst.busy",       32'(busy),       0);
    chk("rst.occ_req",    32'(occ_req),    0);
    chk("rst.food_valid", 32'(food_valid), 0);
    chk("rst.spawn_done", 32'(spawn_done), 0);
    chk("rst.spawn_fail", 32'(spawn_fail), 0);
    rst = 1'b0;
    tick();

    // 1: first draw accepted at (5,10)
    fill_rseq(32'h0285);
    run_spawn("t1", 0, 0);

    // 2: off-grid first draw, then (5,10)
    fill_rseq(32'h0285); rseq[DG + 1] = 32'h003F;
    run_spawn("t2", 0, 0);

    // 3: first lookup occupied, second free
    fill_rseq(32'h0285);
    run_spawn("t3", 1, 0);

    // 4: every lookup occupied -> give up after MT tries
    fill_rseq(32'h0285);
    run_spawn("t4", 99, 0);

    // 5: reset during CHECK aborts the spawn and clears outputs
    fill_rseq(32'h0285);
    run_spawn("t5pre", 0, 0);
    spawn_req = 1'b1; rnd = 16'h0285; occ_hit = 1'b0;
    for (int c = 1; c <= DG + 2; c++) begin
      tick();
      spawn_req = 1'b0;
    end
    chk("t5.occ_req_before_rst", 32'(occ_req), 1);
    rst = 1'b1;
    tick();
    chk("t5.busy",       32'(busy),       0);
    chk("t5.occ_req",    32'(occ_req),    0);
    chk("t5.occ_x",      32'(occ_x),      0);
    chk("t5.occ_y",      32'(occ_y),      0);
    chk("t5.food_x",     32'(food_x),     0);
    chk("t5.food_y",     32'(food_y),     0);
    chk("t5.food_valid", 32'(food_valid), 0);
    chk("t5.spawn_done", 32'(spawn_done), 0);
    chk("t5.spawn_fail", 32'(spawn_fail), 0);
    rst = 1'b0;
    tick();
    run_spawn("t5post", 0, 0);

    // 6: extra requests while busy are ignored; corner cell (39,29) accepted
    fill_rseq(32'h0767);
    run_spawn("t6", 0, 1);

    // Randomized spawns against a random occupancy map
    for (int n = 0; n < 16; n++) begin
      for (int x = 0; x < 40; x++)
        for (int y = 0; y < 30; y++)
          occ[x][y] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 200; i++) rseq[i] = $urandom_range(0, 65535);
      run_spawn("rand", 0, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
